unified_mem_arbiter: RTL and testbench
======================================

// Module: unified_mem_arbiter
// PURPOSE
//  Shares one single-port, fixed-latency unified memory between the instruction-fetch port (IF) and the data-access port (DM).
//  Sits between the multi-cycle core datapath and the memory array.
//  Fixed priority to DM, with a starvation guard for IF.
//  One outstanding transaction at a time; back-to-back issue permitted.
// PARAMETERS
//  ADDR_W        64  byte address width
//  DATA_W        64  data width
//  MEM_LATENCY   2   cycles from mem_en to valid mem_rdata; legal range 1..15
//  STARVE_LIMIT  4   consecutive IF losses before IF is forced to win; legal range 1..15
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  if_req     in   1       fetch request; held with if_addr stable until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       1-cycle pulse: fetch issued to memory this cycle
//  if_rvalid  out  1       1-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetched instruction word (0 when if_rvalid=0)
//  dm_req     in   1       data request; dm_we/dm_addr/dm_wdata held stable until dm_gnt
//  dm_we      in   1       1=store, 0=load
//  dm_addr    in   ADDR_W  data address
//  dm_wdata   in   DATA_W  store data
//  dm_gnt     out  1       1-cycle pulse: data access issued this cycle
//  dm_rvalid  out  1       1-cycle pulse: load data valid or store complete
//  dm_rdata   out  DATA_W  load data; 0 for stores and when dm_rvalid=0
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable (qualified by mem_en)
//  mem_addr   out  ADDR_W  memory address (0 when mem_en=0)
//  mem_wdata  out  DATA_W  memory write data (0 when mem_en=0)
//  mem_rdata  in   DATA_W  read data, valid MEM_LATENCY cycles after mem_en
//  busy       out  1       a transaction is outstanding
// BEHAVIOUR
//  - Reset (async): state=IDLE, latency counter=0, starve counter=0, owner=IF; all outputs 0.
//    Any outstanding transaction is dropped; no rvalid is generated for it after reset.
//  - FSM states:
//    IDLE: no transaction outstanding.
//    WAIT: transaction outstanding; counter counts 1..MEM_LATENCY.
//  - Issue cycle (state IDLE, or WAIT in the rvalid cycle):
//    - Arbitrate combinationally; grant the winner; drive mem_en=1 with the winner's fields.
//    - Latch owner; load counter=1; next state=WAIT. With no request, next state=IDLE.
//  - Zero grant latency: gnt is asserted in the same cycle the request is first seen, if issue is possible.
//  - Winner selection:
//    - dm_req alone -> DM; if_req alone -> IF.
//    - Both requesting: DM wins unless starve counter == STARVE_LIMIT, in which case IF wins.
//  - Starve counter:
//    - +1 on each grant to DM while if_req=1.
//    - Cleared on any IF grant, and in any cycle with if_req=0.
//    - Saturates at STARVE_LIMIT.
//  - WAIT: counter increments each cycle. When counter == MEM_LATENCY:
//    - Owner's rvalid=1; owner's rdata = mem_rdata (load) or 0 (store).
//    - A new issue may occur in this same cycle.
//    - Sustained throughput: one transaction per MEM_LATENCY cycles.
//  - Requests seen in WAIT before the rvalid cycle get no grant; they wait. No other output changes.
//  - The requester owning the outstanding transaction may keep req high for its next access.
//    It is arbitrated normally in the rvalid cycle.
//  - Requesters may deassert req after gnt. Changing fields while req=1 and gnt=0 is a protocol violation; the result is undefined.
//  - Addresses and data pass through unmodified; no alignment checks.
//  - busy = (state == WAIT).
//  - if_gnt and dm_gnt are never both 1; if_rvalid and dm_rvalid are never both 1.
// STRUCTURE
//  - Package mem_arb_pkg: state enum {ARB_IDLE, ARB_WAIT}; owner constants PORT_IF=1'b0, PORT_DM=1'b1.
//  - Sub-module mem_arb_starve_ctr: saturating counter with inc/clr/sat ports.
//  - Top level holds the FSM, latency counter, output mux and response demux.
// TESTING
//  T1 reset: assert reset mid-WAIT with dm load pending -> all outputs 0 immediately; no dm_rvalid afterwards; busy=0.
//  T2 single load (MEM_LATENCY=2):
//     - Cycle 0: dm_req=1, dm_addr=0x40 -> dm_gnt=1, mem_en=1, mem_addr=0x40.
//     - Cycle 2: dm_rvalid=1, dm_rdata=mem_rdata=0xDEAD.
//  T3 collision: if_req and dm_req both high in cycle 0 -> dm_gnt in cycle 0; if_gnt in cycle 2, the same cycle as dm_rvalid.
//  T4 starvation (STARVE_LIMIT=4):
//     - if_req held high; dm_req held high continuously.
//     - DM is granted 4 times, then if_gnt on the 5th issue, then DM resumes.
//  T5 store: dm_we=1, dm_addr=0x80, dm_wdata=0x1234 -> mem_we=1, mem_wdata=0x1234; dm_rvalid 2 cycles later with dm_rdata=0.
//  T6 MEM_LATENCY=1, if_req held high:
//     - if_gnt every cycle; if_rvalid every cycle after the first.
//     - Addresses 0x0, 0x4, 0x8 map to their rdata in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the unified memory arbiter.
//   - arb_state_e : arbiter FSM states (no transaction / transaction outstanding)
//   - PORT_IF/DM  : owner encoding of the outstanding transaction
//   - CNT_W       : width of the latency and starvation counters (limits are 1..15)
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr
//   Saturating counter of consecutive fetch losses.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset
//     inc        : count one more loss (ignored once saturated)
//     clr        : clear to zero; wins over inc
//     sat        : registered, high while the count equals LIMIT
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             sat_r;

    // Next count: clear has priority, increment stops at the limit.
    always_comb begin
        cnt_next_s = cnt_r;
        if (clr) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (inc && (cnt_r != LIMIT_C)) begin
            cnt_next_s = cnt_r + ONE_C;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register and registered saturation flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            sat_r <= (cnt_next_s == LIMIT_C);
        end
    end

    assign sat = sat_r;

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port fixed-latency memory between instruction fetch (IF)
//   and data access (DM). DM has fixed priority; IF is forced to win after
//   STARVE_LIMIT consecutive losses. One transaction outstanding; a new one may
//   issue in the cycle the previous response returns.
//   Ports:
//     clk, reset                    : clock, asynchronous active-high reset
//     if_req/if_addr                : fetch request (held until if_gnt)
//     if_gnt/if_rvalid/if_rdata     : fetch grant pulse, response pulse and data
//     dm_req/dm_we/dm_addr/dm_wdata : data request (held until dm_gnt)
//     dm_gnt/dm_rvalid/dm_rdata     : data grant pulse, response pulse, load data
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata : memory interface
//     busy                          : a transaction is outstanding
//   Grants and the memory strobe are combinational so a request is granted in
//   the cycle it is first seen whenever issue is possible.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    arb_state_e       state_r;
    logic [CNT_W-1:0] lat_cnt_r;
    logic             owner_r;
    logic             owner_we_r;

    logic             rsp_s;
    logic             issue_ok_s;
    logic             sat_s;
    logic             if_gnt_s;
    logic             dm_gnt_s;
    logic             mem_en_s;
    logic             mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic             if_rvalid_s;
    logic             dm_rvalid_s;
    logic [DATA_W-1:0] if_rdata_s;
    logic [DATA_W-1:0] dm_rdata_s;

    // The response cycle doubles as an issue slot; reset blocks issue at once.
    assign rsp_s      = (state_r == ARB_WAIT) && (lat_cnt_r == LAT_C);
    assign issue_ok_s = !reset && ((state_r == ARB_IDLE) || rsp_s);

    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc   (dm_gnt_s && if_req),
        .clr   (if_gnt_s || !if_req),
        .sat   (sat_s)
    );

    // Arbitration: DM wins a collision unless IF has lost too often in a row.
    always_comb begin
        if_gnt_s = 1'b0;
        dm_gnt_s = 1'b0;
        if (issue_ok_s) begin
            if (dm_req && !(if_req && sat_s)) begin
                dm_gnt_s = 1'b1;
            end else if (if_req) begin
                if_gnt_s = 1'b1;
            end else begin
                if_gnt_s = 1'b0;
                dm_gnt_s = 1'b0;
            end
        end else begin
            if_gnt_s = 1'b0;
            dm_gnt_s = 1'b0;
        end
    end

    // Memory request mux: winner's fields, all zero when nothing issues.
    always_comb begin
        mem_en_s    = if_gnt_s | dm_gnt_s;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        if (dm_gnt_s) begin
            mem_we_s    = dm_we;
            mem_addr_s  = dm_addr;
            mem_wdata_s = dm_wdata;
        end else if (if_gnt_s) begin
            mem_addr_s  = if_addr;
        end else begin
            mem_we_s    = 1'b0;
        end
    end

    // FSM with latency counter and owner latch; an issue always (re)starts WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ARB_IDLE;
            lat_cnt_r  <= {CNT_W{1'b0}};
            owner_r    <= PORT_IF;
            owner_we_r <= 1'b0;
        end else if (mem_en_s) begin
            state_r    <= ARB_WAIT;
            lat_cnt_r  <= ONE_C;
            owner_r    <= dm_gnt_s ? PORT_DM : PORT_IF;
            owner_we_r <= dm_gnt_s & dm_we;
        end else begin
            case (state_r)
                ARB_WAIT: begin
                    if (rsp_s) begin
                        state_r   <= ARB_IDLE;
                        lat_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        lat_cnt_r <= lat_cnt_r + ONE_C;
                    end
                end
                default: begin
                    state_r   <= ARB_IDLE;
                    lat_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Response demux to the owner; stores complete with zero data.
    always_comb begin
        if_rvalid_s = 1'b0;
        dm_rvalid_s = 1'b0;
        if_rdata_s  = {DATA_W{1'b0}};
        dm_rdata_s  = {DATA_W{1'b0}};
        if (rsp_s) begin
            if (owner_r == PORT_DM) begin
                dm_rvalid_s = 1'b1;
                if (!owner_we_r) begin
                    dm_rdata_s = mem_rdata;
                end else begin
                    dm_rdata_s = {DATA_W{1'b0}};
                end
            end else begin
                if_rvalid_s = 1'b1;
                if_rdata_s  = mem_rdata;
            end
        end else begin
            if_rvalid_s = 1'b0;
            dm_rvalid_s = 1'b0;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign dm_gnt    = dm_gnt_s;
    assign if_rvalid = if_rvalid_s;
    assign dm_rvalid = dm_rvalid_s;
    assign if_rdata  = if_rdata_s;
    assign dm_rdata  = dm_rdata_s;
    assign mem_en    = mem_en_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;
    assign busy      = (state_r == ARB_WAIT);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Testbench for unified_mem_arbiter: two instances (latency 2 / limit 4 and
// latency 1 / limit 3), a time-based transaction model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_unified_mem_arbiter;

    localparam int LAT0 = 2, LIM0 = 4;
    localparam int LAT1 = 1, LIM1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        if_req [2];
    logic [63:0] if_addr [2];
    logic        dm_req [2];
    logic        dm_we [2];
    logic [63:0] dm_addr [2];
    logic [63:0] dm_wdata [2];
    logic        if_gnt [2], if_rvalid [2], dm_gnt [2], dm_rvalid [2];
    logic        mem_en [2], mem_we [2], busy [2];
    logic [63:0] if_rdata [2], dm_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

    logic [63:0] hist [2][16];
    logic [63:0] mem_cap [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: outstanding transaction described by its due cycle.
    longint      cyc = 0;
    bit          m_out [2];
    longint      m_due [2];
    bit          m_dm [2];
    bit          m_we [2];
    logic [63:0] m_addr [2];
    int          m_starve [2];
    int          lat_of [2] = '{LAT0, LAT1};
    int          lim_of [2] = '{LIM0, LIM1};

    logic        e_rsp, e_can, e_dg, e_ig, e_irv, e_drv, e_me;
    logic [63:0] e_ird, e_drd, e_ma;
    logic        gi [2], gd [2];

    unified_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(LAT0), .STARVE_LIMIT(LIM0)) u0 (
        .clk(clk), .reset(reset),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
        .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
        .dm_gnt(dm_gnt[0]), .dm_rvalid(dm_rvalid[0]), .dm_rdata(dm_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0]));

    unified_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LATENCY(LAT1), .STARVE_LIMIT(LIM1)) u1 (
        .clk(clk), .reset(reset),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
        .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
        .dm_gnt(dm_gnt[1]), .dm_rvalid(dm_rvalid[1]), .dm_rdata(dm_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1]));

    // Memory contents as a function of address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h40) return 64'hDEAD;
        return a * 64'h9E37_79B9_7F4A_7C15 + 64'd1;
    endfunction

    // Fixed-latency memory: data for the address issued LAT cycles earlier.
    assign mem_rdata[0] = mem_word(hist[0][LAT0-1]);
    assign mem_rdata[1] = mem_word(hist[1][LAT1-1]);

    initial begin
        for (int k = 0; k < 2; k++) begin
            mem_cap[k] = 64'd0;
            for (int i = 0; i < 16; i++) hist[k][i] = 64'd0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
                hist[k][0] = mem_cap[k];
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle model compare (mid-cycle, on the falling edge).
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                mem_cap[k] = mem_en[k] ? mem_addr[k] : 64'd0;
                if (reset) begin
                    chk("m_rst_busy", k, busy[k], 64'd0);
                    chk("m_rst_gnt", k, {if_gnt[k], dm_gnt[k]}, 64'd0);
                    chk("m_rst_rvalid", k, {if_rvalid[k], dm_rvalid[k]}, 64'd0);
                    chk("m_rst_mem_en", k, mem_en[k], 64'd0);
                    chk("m_rst_mem_addr", k, mem_addr[k], 64'd0);
                    chk("m_rst_rdata", k, if_rdata[k] | dm_rdata[k], 64'd0);
                    m_out[k]    = 1'b0;
                    m_starve[k] = 0;
                end else begin
                    e_rsp = m_out[k] && (cyc == m_due[k]);
                    e_can = !m_out[k] || e_rsp;
                    e_dg  = e_can && dm_req[k] && !(if_req[k] && (m_starve[k] == lim_of[k]));
                    e_ig  = e_can && if_req[k] && !e_dg;
                    e_me  = e_dg || e_ig;
                    e_irv = e_rsp && !m_dm[k];
                    e_drv = e_rsp && m_dm[k];
                    e_ird = e_irv ? mem_word(m_addr[k]) : 64'd0;
                    e_drd = (e_drv && !m_we[k]) ? mem_word(m_addr[k]) : 64'd0;
                    e_ma  = e_dg ? dm_addr[k] : (e_ig ? if_addr[k] : 64'd0);
                    chk("m_busy", k, busy[k], m_out[k]);
                    chk("m_if_gnt", k, if_gnt[k], e_ig);
                    chk("m_dm_gnt", k, dm_gnt[k], e_dg);
                    chk("m_if_rvalid", k, if_rvalid[k], e_irv);
                    chk("m_dm_rvalid", k, dm_rvalid[k], e_drv);
                    chk("m_if_rdata", k, if_rdata[k], e_ird);
                    chk("m_dm_rdata", k, dm_rdata[k], e_drd);
                    chk("m_mem_en", k, mem_en[k], e_me);
                    chk("m_mem_we", k, mem_we[k], e_dg && dm_we[k]);
                    chk("m_mem_addr", k, mem_addr[k], e_ma);
                    if (!e_me) chk("m_mem_wdata_idle", k, mem_wdata[k], 64'd0);
                    else if (e_dg && dm_we[k]) chk("m_mem_wdata", k, mem_wdata[k], dm_wdata[k]);
                    if (e_me) begin
                        m_out[k]  = 1'b1;
                        m_due[k]  = cyc + lat_of[k];
                        m_dm[k]   = e_dg;
                        m_we[k]   = e_dg && dm_we[k];
                        m_addr[k] = e_ma;
                    end else if (e_rsp) begin
                        m_out[k] = 1'b0;
                    end
                    if (!if_req[k] || e_ig) m_starve[k] = 0;
                    else if (e_dg && (m_starve[k] < lim_of[k])) m_starve[k]++;
                end
            end
            cyc++;
        end
    end

    // Stimulus: directed scenarios, then randomized traffic.
    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = 64'd0;
            dm_req[k] = 1'b0; dm_we[k] = 1'b0; dm_addr[k] = 64'd0; dm_wdata[k] = 64'd0;
        end
        step();
        @(negedge clk);
        chk("rst_busy", 0, busy[0], 64'd0);
        chk("rst_mem_en", 0, mem_en[0], 64'd0);
        step();
        reset = 1'b0;
        step();

        // Single load at 0x40.
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 64'h40;
        @(negedge clk);
        chk("t2_dm_gnt", 0, dm_gnt[0], 64'd1);
        chk("t2_mem_en", 0, mem_en[0], 64'd1);
        chk("t2_mem_addr", 0, mem_addr[0], 64'h40);
        step();
        dm_req[0] = 1'b0;
        @(negedge clk);
        chk("t2_busy", 0, busy[0], 64'd1);
        chk("t2_no_rvalid", 0, dm_rvalid[0], 64'd0);
        step();
        @(negedge clk);
        chk("t2_dm_rvalid", 0, dm_rvalid[0], 64'd1);
        chk("t2_dm_rdata", 0, dm_rdata[0], 64'hDEAD);
        step();

        // Collision: DM first, IF in DM's response cycle.
        if_req[0] = 1'b1; if_addr[0] = 64'h100;
        dm_req[0] = 1'b1; dm_addr[0] = 64'h200;
        @(negedge clk);
        chk("t3_dm_gnt", 0, dm_gnt[0], 64'd1);
        chk("t3_if_gnt0", 0, if_gnt[0], 64'd0);
        step();
        dm_req[0] = 1'b0;
        @(negedge clk);
        chk("t3_if_wait", 0, if_gnt[0], 64'd0);
        step();
        @(negedge clk);
        chk("t3_if_gnt2", 0, if_gnt[0], 64'd1);
        chk("t3_dm_rvalid2", 0, dm_rvalid[0], 64'd1);
        step();
        if_req[0] = 1'b0;
        step();
        step();

        // Starvation guard: four DM wins, IF forced on the fifth issue.
        if_req[0] = 1'b1; if_addr[0] = 64'h300;
        dm_req[0] = 1'b1; dm_addr[0] = 64'h400;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_dm_gnt", 0, dm_gnt[0], (i != 4) ? 64'd1 : 64'd0);
            chk("t4_if_gnt", 0, if_gnt[0], (i == 4) ? 64'd1 : 64'd0);
            step();
            step();
        end
        if_req[0] = 1'b0; dm_req[0] = 1'b0;
        step();
        step();

        // Store.
        dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 64'h80; dm_wdata[0] = 64'h1234;
        @(negedge clk);
        chk("t5_mem_we", 0, mem_we[0], 64'd1);
        chk("t5_mem_wdata", 0, mem_wdata[0], 64'h1234);
        chk("t5_mem_addr", 0, mem_addr[0], 64'h80);
        step();
        dm_req[0] = 1'b0; dm_we[0] = 1'b0;
        step();
        @(negedge clk);
        chk("t5_dm_rvalid", 0, dm_rvalid[0], 64'd1);
        chk("t5_dm_rdata", 0, dm_rdata[0], 64'd0);
        step();
        step();

        // Reset mid-WAIT drops the pending load.
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 64'h40;
        @(negedge clk);
        chk("t1_dm_gnt", 0, dm_gnt[0], 64'd1);
        step();
        dm_req[0] = 1'b0;
        reset = 1'b1;
        #1;
        chk("t1_busy", 0, busy[0], 64'd0);
        chk("t1_dm_rvalid", 0, dm_rvalid[0], 64'd0);
        chk("t1_mem_en", 0, mem_en[0], 64'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_no_rvalid", 0, dm_rvalid[0], 64'd0);
            chk("t1_idle", 0, busy[0], 64'd0);
            step();
        end

        // Latency 1 with fetch held: one issue every cycle.
        if_req[1] = 1'b1; if_addr[1] = 64'h0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t6_if_gnt", 1, if_gnt[1], 64'd1);
            if (j == 0) chk("t6_first_rvalid", 1, if_rvalid[1], 64'd0);
            else begin
                chk("t6_if_rvalid", 1, if_rvalid[1], 64'd1);
                chk("t6_if_rdata", 1, if_rdata[1], mem_word(64'(4 * (j - 1))));
            end
            if (j == 1) chk("t6_rdata_addr0", 1, if_rdata[1], 64'd1);
            step();
            if_addr[1] = 64'(4 * (j + 1));
        end
        if_req[1] = 1'b0;
        step();
        step();

        // Randomized traffic on both instances, with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                gi[k] = if_gnt[k];
                gd[k] = dm_gnt[k];
            end
            step();
            reset = ($urandom_range(0, 299) == 0);
            for (int k = 0; k < 2; k++) begin
                if (!if_req[k] || gi[k]) begin
                    if_req[k]  = ($urandom_range(0, 3) != 0);
                    if_addr[k] = {$urandom, $urandom};
                end
                if (!dm_req[k] || gd[k]) begin
                    dm_req[k]   = ($urandom_range(0, 3) != 0);
                    dm_we[k]    = $urandom_range(0, 1) == 1;
                    dm_addr[k]  = {$urandom, $urandom};
                    dm_wdata[k] = {$urandom, $urandom};
                end
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0;
            dm_req[k] = 1'b0;
        end
        for (int i = 0; i < 5; i++) step();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
